rv32_clint_mh: RTL
==================

// Module: rv32_clint_mh
// PURPOSE
//  Multi-hart CLINT: one shared 64-bit MTIME, plus per-hart MSIP and 64-bit MTIMECMP, on an APB-style slave port.
//  Drives per-hart software and timer interrupt lines into each core's MIP.
//  MTIME runs continuously on synchronised RTC rising edges, including during bus accesses.
// PARAMETERS
//  ADDRW   16  slave address width in bits (>=16)
//  XLEN    32  data width; only 32 is supported
//  NHARTS  1   number of harts (1..16)
// PORTS
//  CLK        in   1         core clock
//  RSTN       in   1         asynchronous, active-low reset
//  s_en       in   1         access request; held until s_ready
//  s_wr       in   1         1=write, 0=read
//  s_addr     in   ADDRW     byte address; bits [1:0] ignored
//  s_wdata    in   XLEN      write data
//  s_strb     in   XLEN/8    byte enables for writes
//  s_rdata    out  XLEN      read data, valid while s_ready=1
//  s_ready    out  1         one-cycle completion pulse
//  s_err      out  1         unmapped address; valid while s_ready=1
//  rtc        in   1         asynchronous real-time tick
//  sw_irq     out  NHARTS    per-hart MSIP bit
//  timer_irq  out  NHARTS    per-hart timer interrupt
// BEHAVIOUR
//  Reset values:
//   - s_rdata=0, s_ready=0, s_err=0, sw_irq=0, timer_irq=0.
//   - mtime=0; every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, so no interrupt fires out of reset.
//  Register map (offset = s_addr[15:0]):
//   - 0x0000+4h = MSIP[h]: bit0 read/write, upper bits read 0.
//   - 0x4000+8h = MTIMECMP[h] low word; 0x4004+8h = MTIMECMP[h] high word.
//   - 0xBFF8 = MTIME low word; 0xBFFC = MTIME high word.
//   - Any other offset, including h>=NHARTS, is unmapped.
//  Handshake:
//   - An access commits in the cycle with s_en=1 and s_ready=0.
//   - The next cycle s_ready=1, with s_rdata/s_err valid; then s_ready returns to 0.
//   - Exactly one commit per request; back-to-back requests give a 2-cycle throughput.
//  Reads return the pre-write value of the register.
//  Writes apply per byte under s_strb; s_strb=0 is a no-op.
//  Unmapped access: s_rdata=0, s_err=1, no state changes.
//  RTC path:
//   - rtc passes through rv32_2dffsync, then a rising-edge detector; tick = one CLK pulse per rtc rising edge.
//   - On a tick, mtime increments by 1 with modulo-2^64 wrap (FFFF..FF -> 0).
//  Simultaneous MTIME write and tick: the written bytes take the written value; unwritten bytes take the incremented value.
//  Timer interrupt:
//   - timer_irq[h] is registered and equals (mtime >= mtimecmp[h]) one cycle after either operand changes.
//   - The compare is unsigned over all 64 bits.
//   - Writing MTIMECMP above MTIME clears the interrupt on the following cycle.
//  Reset asserted mid-access: s_ready is dropped immediately, all state returns to its reset value, and the pending write is lost.
// CONFIGURATION
//  CLINT_MTIME_LATCH_EN defined:
//   - A read of the MTIME low word snapshots mtime[63:32] into a shadow register.
//   - A read of the high word at 0xBFFC returns the shadow, giving a tear-free 64-bit read pair.
//   - The shadow resets to 0.
//  CLINT_MTIME_LATCH_EN undefined: a read at 0xBFFC returns live mtime[63:32].
// STRUCTURE
//  rv32_clint_pkg:
//   - Offset constants: CLINT_MSIP_BASE, CLINT_MTIMECMP_BASE, CLINT_MTIME_LO, CLINT_MTIME_HI.
//   - Function: clint_strb_merge(old, wdata, strb).
//   - typedef clint_sel_e: SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI, SEL_MTIME_LO, SEL_MTIME_HI, SEL_NONE.
//  Sub-module rv32_clint_hart, instanced NHARTS times:
//   - Holds msip and mtimecmp and implements the registered compare.
//   - Takes mtime, decoded write strobes and write data; returns its read data.
//  Top level holds the address decode, handshake, mtime counter, RTC synchroniser/edge detector and read mux.
//  rv32_2dffsync is reused unchanged.
// TESTING
//  1. Reset, then read 0x4000/0x4004 -> FFFF_FFFF each with s_err=0; timer_irq=0; s_ready pulses once per request.
//  2. NHARTS=2:
//     - Write 1 to 0x0004 -> sw_irq=2'b10, read returns 1.
//     - Write 0x0000 with s_strb=0 -> sw_irq unchanged.
//  3. Write MTIME=0xFFFF_FFFF (low) and 0 (high), apply 1 rtc edge -> MTIME reads low 0, high 1 (carry across words).
//  4. Write MTIMECMP[0]=5 (high word 0), apply 5 rtc edges -> timer_irq[0] rises 1 cycle after mtime=5, timer_irq[1] stays 0.
//     Then write MTIMECMP[0]=100 -> irq clears next cycle.
//  5. Read 0x8000 -> s_rdata=0, s_err=1; a write to 0x8000 changes no register.
//  6. CLINT_MTIME_LATCH_EN:
//     - Set mtime low=0xFFFF_FFFF; read low; apply an rtc edge; read high -> returns the pre-carry high value.
//     - Without the macro -> returns pre-carry+1.

Source files
------------

// File: rtl/rv32_clint_pkg.sv
// Shared CLINT definitions: register offsets, access selector type and byte-strobe merge helper.
package rv32_clint_pkg;

    localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI      = 16'hBFFC;

    typedef enum logic [2:0] {
        SEL_MSIP     = 3'd0,
        SEL_CMP_LO   = 3'd1,
        SEL_CMP_HI   = 3'd2,
        SEL_MTIME_LO = 3'd3,
        SEL_MTIME_HI = 3'd4,
        SEL_NONE     = 3'd5
    } clint_sel_e;

    function automatic logic [31:0] clint_strb_merge(input logic [31:0] old_w,
                                                     input logic [31:0] wdata,
                                                     input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rv32_clint_mh_if.sv
// APB-style request/complete slave bus of the CLINT.
interface rv32_clint_mh_if #(
    parameter int ADDRW = 16,
    parameter int XLEN  = 32
);
    logic              s_en;
    logic              s_wr;
    logic [ADDRW-1:0]  s_addr;
    logic [XLEN-1:0]   s_wdata;
    logic [XLEN/8-1:0] s_strb;
    logic [XLEN-1:0]   s_rdata;
    logic              s_ready;
    logic              s_err;

    modport master (output s_en, s_wr, s_addr, s_wdata, s_strb,
                    input  s_rdata, s_ready, s_err);
    modport slave  (input  s_en, s_wr, s_addr, s_wdata, s_strb,
                    output s_rdata, s_ready, s_err);
endinterface

// File: rtl/rv32_2dffsync.sv
// Two-flop synchroniser for a single asynchronous input.
module rv32_2dffsync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Double-register the asynchronous input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/rv32_clint_hart.sv
// Per-hart CLINT state: MSIP bit, 64-bit MTIMECMP and the registered timer compare.
module rv32_clint_hart
    import rv32_clint_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [63:0] mtime_i,
    input  logic        we_i,
    input  clint_sel_e  sel_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  strb_i,
    output logic [31:0] rdata_o,
    output logic        msip_o,
    output logic        timer_irq_o
);
    logic        msip_q, msip_d;
    logic [63:0] cmp_q, cmp_d;
    logic        irq_q;

    // Next-state for the writable registers.
    always_comb begin
        msip_d = msip_q;
        cmp_d  = cmp_q;
        if (we_i) begin
            case (sel_i)
                SEL_MSIP:   msip_d = strb_i[0] ? wdata_i[0] : msip_q;
                SEL_CMP_LO: cmp_d[31:0]  = clint_strb_merge(cmp_q[31:0], wdata_i, strb_i);
                SEL_CMP_HI: cmp_d[63:32] = clint_strb_merge(cmp_q[63:32], wdata_i, strb_i);
                default:    cmp_d = cmp_q;
            endcase
        end else begin
            cmp_d = cmp_q;
        end
    end

    // Read data for the addressed register of this hart.
    always_comb begin
        case (sel_i)
            SEL_MSIP:   rdata_o = {31'd0, msip_q};
            SEL_CMP_LO: rdata_o = cmp_q[31:0];
            SEL_CMP_HI: rdata_o = cmp_q[63:32];
            default:    rdata_o = 32'd0;
        endcase
    end

    // State registers and the registered unsigned compare.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            msip_q <= 1'b0;
            cmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            irq_q  <= 1'b0;
        end else begin
            msip_q <= msip_d;
            cmp_q  <= cmp_d;
            irq_q  <= (mtime_i >= cmp_q);
        end
    end

    assign msip_o      = msip_q;
    assign timer_irq_o = irq_q;
endmodule

// File: rtl/rv32_clint_mh.sv
// Multi-hart CLINT top: decode, handshake, shared mtime counter and RTC tick path.
// Optional CLINT_MTIME_LATCH_EN: reading MTIME low snapshots the high word for a tear-free pair.
module rv32_clint_mh
    import rv32_clint_pkg::*;
#(
    parameter int ADDRW  = 16,
    parameter int XLEN   = 32,
    parameter int NHARTS = 1
) (
    input  logic              CLK,
    input  logic              RSTN,
    rv32_clint_mh_if.slave    bus,
    input  logic              rtc,
    output logic [NHARTS-1:0] sw_irq,
    output logic [NHARTS-1:0] timer_irq
);
    localparam logic [15:0] MSIP_END = CLINT_MSIP_BASE + 16'(4 * NHARTS);
    localparam logic [15:0] CMP_END  = CLINT_MTIMECMP_BASE + 16'(8 * NHARTS);

    logic [ADDRW-1:0] addr_s;
    logic [15:0]      off_s;
    clint_sel_e       sel_s;
    logic [3:0]       hart_s;
    logic             commit_s, wr_commit_s;
    logic             ready_q, err_q;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic [63:0]      mtime_q, mtime_d, mtime_inc_s;
    logic [31:0]      mtime_hi_rd_s, hart_rd_s;
    logic [31:0]      hart_rdata_s [NHARTS];
    logic             rtc_sync_s, rtc_prev_q, tick_s;

    assign addr_s      = bus.s_addr;
    assign off_s       = addr_s[15:0];
    assign commit_s    = bus.s_en & ~ready_q;
    assign wr_commit_s = commit_s & bus.s_wr;

    // Address decode into register class and hart index.
    always_comb begin
        sel_s  = SEL_NONE;
        hart_s = 4'd0;
        if (off_s < MSIP_END) begin
            sel_s  = SEL_MSIP;
            hart_s = off_s[5:2];
        end else if (off_s >= CLINT_MTIMECMP_BASE && off_s < CMP_END) begin
            sel_s  = off_s[2] ? SEL_CMP_HI : SEL_CMP_LO;
            hart_s = off_s[6:3];
        end else if (off_s >= CLINT_MTIME_LO && off_s <= CLINT_MTIME_HI + 16'd3) begin
            sel_s  = off_s[2] ? SEL_MTIME_HI : SEL_MTIME_LO;
        end else begin
            sel_s  = SEL_NONE;
        end
    end

    rv32_2dffsync u_rtc_sync (
        .clk_i  (CLK),
        .rst_ni (RSTN),
        .d_i    (rtc),
        .q_o    (rtc_sync_s)
    );
    assign tick_s = rtc_sync_s & ~rtc_prev_q;

    // Written mtime bytes override the incremented value; unwritten bytes keep the increment.
    always_comb begin
        mtime_inc_s = tick_s ? mtime_q + 64'd1 : mtime_q;
        mtime_d     = mtime_inc_s;
        if (wr_commit_s && sel_s == SEL_MTIME_LO) begin
            mtime_d[31:0] = clint_strb_merge(mtime_inc_s[31:0], bus.s_wdata, bus.s_strb);
        end else if (wr_commit_s && sel_s == SEL_MTIME_HI) begin
            mtime_d[63:32] = clint_strb_merge(mtime_inc_s[63:32], bus.s_wdata, bus.s_strb);
        end else begin
            mtime_d = mtime_inc_s;
        end
    end

    for (genvar h = 0; h < NHARTS; h++) begin : g_hart
        rv32_clint_hart u_hart (
            .clk_i       (CLK),
            .rst_ni      (RSTN),
            .mtime_i     (mtime_q),
            .we_i        (wr_commit_s && hart_s == 4'(h)),
            .sel_i       (sel_s),
            .wdata_i     (bus.s_wdata),
            .strb_i      (bus.s_strb),
            .rdata_o     (hart_rdata_s[h]),
            .msip_o      (sw_irq[h]),
            .timer_irq_o (timer_irq[h])
        );
    end

`ifdef CLINT_MTIME_LATCH_EN
    logic [31:0] shadow_q;

    // Snapshot the high word on every committed read of the low word.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            shadow_q <= 32'd0;
        end else if (commit_s && !bus.s_wr && sel_s == SEL_MTIME_LO) begin
            shadow_q <= mtime_q[63:32];
        end else begin
            shadow_q <= shadow_q;
        end
    end
    assign mtime_hi_rd_s = shadow_q;
`else
    assign mtime_hi_rd_s = mtime_q[63:32];
`endif

    // Select the addressed hart's read data.
    always_comb begin
        hart_rd_s = 32'd0;
        for (int h = 0; h < NHARTS; h++) begin
            hart_rd_s = hart_rd_s | (hart_rdata_s[h] & {32{hart_s == 4'(h)}});
        end
    end

    // Read mux; unmapped offsets return zero.
    always_comb begin
        case (sel_s)
            SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI: rdata_d = hart_rd_s;
            SEL_MTIME_LO:                     rdata_d = mtime_q[31:0];
            SEL_MTIME_HI:                     rdata_d = mtime_hi_rd_s;
            default:                          rdata_d = {XLEN{1'b0}};
        endcase
    end

    // Handshake response, mtime counter and RTC edge history.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= {XLEN{1'b0}};
            mtime_q    <= 64'd0;
            rtc_prev_q <= 1'b0;
        end else begin
            ready_q    <= commit_s;
            mtime_q    <= mtime_d;
            rtc_prev_q <= rtc_sync_s;
            if (commit_s) begin
                rdata_q <= rdata_d;
                err_q   <= (sel_s == SEL_NONE);
            end else begin
                rdata_q <= rdata_q;
                err_q   <= err_q;
            end
        end
    end

    assign bus.s_ready = ready_q;
    assign bus.s_rdata = rdata_q;
    assign bus.s_err   = err_q;
endmodule
